// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and store-encoding helpers for the load/store unit.
// Provides the FSM state enum, RV32I width codes, strobe and lane-replication functions.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      WB
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic [3:0] lsu_strb(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic [3:0] s;
      s = 4'b0000;
      case (f3)
         F3_B:    s = 4'b0001 << a;
         F3_H:    s = 4'b0011 << {a[1], 1'b0};
         F3_W:    s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] lsu_wdata(
      input logic [2:0]  f3,
      input logic [31:0] d
   );
      logic [31:0] w;
      w = d;
      case (f3)
         F3_B:    w = {4{d[7:0]}};
         F3_H:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic lsu_legal(
      input logic       we,
      input logic [2:0] f3
   );
      logic ok;
      if (we)
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory bus bundle of the load/store unit.
// slave: the unit's view; master: the core/memory side that drives requests and responses.
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [REG_AW-1:0] req_rd;

   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      output req_ready,
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a loaded word and sign/zero-extends it.
// Ports: rdata (memory word), addr (low address bits), funct3 (width/sign), data (result).
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = rdata[7:0];
      case (addr)
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         2'd3:    b = rdata[31:24];
         default: b = rdata[7:0];
      endcase
      h = addr[1] ? rdata[31:16] : rdata[15:0];
      data = rdata;
      case (funct3)
         F3_B:    data = {{24{b[7]}}, b};
         F3_BU:   data = {24'd0, b};
         F3_H:    data = {{16{h[15]}}, h};
         F3_HU:   data = {16'd0, h};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, word-aligned memory access, load write-back.
// Ports: clk, rst (async high), bus (request + memory), rf_we/rf_waddr/rf_wdata, done, misalign_err.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are trapped instead of lane-forced.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [31:0]       rf_wdata,
   output logic              done,
   output logic              misalign_err
);
   lsu_state_t state, state_nx;

   logic              accept;
   logic              mis;
   logic              bad;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        lane_q;
   logic [REG_AW-1:0] rd_q;
   logic              skip_q;
   logic              mis_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [3:0]        mem_wstrb_q;
   logic [31:0]       mem_wdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       ext;

   assign accept = (state == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      mis = 1'b0;
      if (lsu_legal(bus.req_we, bus.req_funct3)) begin
         if (bus.req_funct3[1:0] == 2'b01)
            mis = bus.req_addr[0];
         else if (bus.req_funct3 == F3_W)
            mis = (bus.req_addr[1:0] != 2'b00);
      end
   end
`else
   assign mis = 1'b0;
`endif

   // Illegal or trapped requests skip the memory phase and go straight to WB.
   assign bad = !lsu_legal(bus.req_we, bus.req_funct3) || mis;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.req_valid) state_nx = bad ? WB : REQ;
         REQ:  if (bus.mem_ready) state_nx = we_q ? WB : WAIT;
         WAIT: if (bus.mem_rvalid) state_nx = WB;
         WB:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         lane_q      <= 2'd0;
         rd_q        <= '0;
         skip_q      <= 1'b0;
         mis_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= 4'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
      end else begin
         if (accept) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            lane_q      <= bus.req_addr[1:0];
            rd_q        <= bus.req_rd;
            skip_q      <= bad;
            mis_q       <= mis;
            mem_we_q    <= bus.req_we && !bad;
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_q <= (bus.req_we && !bad) ?
                           lsu_strb(bus.req_funct3, bus.req_addr[1:0]) : 4'd0;
            mem_wdata_q <= lsu_wdata(bus.req_funct3, bus.req_wdata);
         end
         if ((state == WAIT) && bus.mem_rvalid)
            rdata_q <= bus.mem_rdata;
      end
   end

   lsu_load_align u_align (
      .rdata  (rdata_q),
      .addr   (lane_q),
      .funct3 (f3_q),
      .data   (ext)
   );

   assign bus.req_ready = (state == IDLE);
   assign bus.mem_valid = (state == REQ);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign done         = (state == WB);
   assign rf_we        = (state == WB) && !we_q && !skip_q && (rd_q != '0);
   assign rf_waddr     = rd_q;
   assign rf_wdata     = ext;
   assign misalign_err = (state == WB) && mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural model.
// Follows LSU_MISALIGN_TRAP_EN when defined for the build.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        done;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   load_store_unit_if #(.ADDR_W(32), .REG_AW(5)) bus ();

   load_store_unit #(.ADDR_W(32), .REG_AW(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .done         (done),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit m_legal(input bit we, input int f3);
      if (we) return f3 <= 2;
      return (f3 <= 2) || (f3 == 4) || (f3 == 5);
   endfunction

   function automatic bit m_mis(input bit we, input int f3,
                                input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      if (!m_legal(we, f3)) return 0;
      if ((f3 == 1 || f3 == 5) && a[0]) return 1;
      if (f3 == 2 && (a % 4) != 0) return 1;
      return 0;
`else
      return (we && f3 > 7) || (a > 32'hFFFFFFFF);
`endif
   endfunction

   function automatic logic [3:0] m_strb(input int f3, input logic [31:0] a);
      if (f3 == 0) return 4'(1 << (a % 4));
      if (f3 == 1) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
      if (f3 == 0) return (d % 256) * 32'h01010101;
      if (f3 == 1) return (d % 65536) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input int f3, input logic [31:0] a,
                                          input logic [31:0] r);
      logic [31:0] v;
      if (f3 == 0 || f3 == 4) begin
         v = (r >> (8 * (a % 4))) % 256;
         if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
         return v;
      end
      if (f3 == 1 || f3 == 5) begin
         v = (r >> (16 * ((a / 2) % 2))) % 65536;
         if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
         return v;
      end
      return r;
   endfunction

   task automatic run_txn(input bit we, input int f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int rdy, input int rv, input logic [31:0] rdat);
      bit ok;
      bit trap;
      bit skip;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1;
            break;
         end
      end
      chk("req_ready_wait", 32'(ok), 32'd1);
      if (!ok) return;
      trap = m_mis(we, f3, a);
      skip = !m_legal(we, f3) || trap;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = 3'(f3);
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      bus.req_rd     = rd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      @(negedge clk);
      if (skip) begin
         chk("skip_done", 32'(done), 32'd1);
         chk("skip_mis", 32'(misalign_err), 32'(trap));
         chk("skip_mvalid", 32'(bus.mem_valid), 32'd0);
         chk("skip_rfwe", 32'(rf_we), 32'd0);
         chk("skip_ready", 32'(bus.req_ready), 32'd0);
      end else begin
         for (int k = 0; k <= rdy; k++) begin
            chk("mvalid", 32'(bus.mem_valid), 32'd1);
            chk("mwe", 32'(bus.mem_we), 32'(we));
            chk("maddr", bus.mem_addr, a & ~32'd3);
            chk("mstrb", 32'(bus.mem_wstrb), we ? 32'(m_strb(f3, a)) : 32'd0);
            if (we) chk("mwdata", bus.mem_wdata, m_wdata(f3, wd));
            chk("req_busy", 32'(bus.req_ready), 32'd0);
            chk("done_early", 32'(done), 32'd0);
            if (k == rdy) begin
               bus.mem_ready = 1'b1;
               @(posedge clk);
               #1 bus.mem_ready = 1'b0;
            end else begin
               @(negedge clk);
            end
         end
         @(negedge clk);
         if (!we) begin
            for (int k = 0; k <= rv; k++) begin
               chk("wait_mvalid", 32'(bus.mem_valid), 32'd0);
               chk("wait_done", 32'(done), 32'd0);
               chk("wait_rfwe", 32'(rf_we), 32'd0);
               if (k == rv) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = rdat;
                  @(posedge clk);
                  #1 bus.mem_rvalid = 1'b0;
                  bus.mem_rdata = $urandom;
               end else begin
                  @(negedge clk);
               end
            end
            @(negedge clk);
            chk("ld_rfwe", 32'(rf_we), 32'(rd != 0));
            if (rd != 0) begin
               chk("ld_waddr", 32'(rf_waddr), 32'(rd));
               chk("ld_wdata", rf_wdata, m_load(f3, a, rdat));
            end
         end else begin
            chk("st_rfwe", 32'(rf_we), 32'd0);
         end
         chk("done", 32'(done), 32'd1);
         chk("mis_clear", 32'(misalign_err), 32'd0);
         chk("done_mvalid", 32'(bus.mem_valid), 32'd0);
         chk("done_ready", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.req_rd     = 5'd0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_mvalid", 32'(bus.mem_valid), 32'd0);
      chk("rst_mwe", 32'(bus.mem_we), 32'd0);
      chk("rst_strb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_maddr", bus.mem_addr, 32'd0);
      chk("rst_rfwe", 32'(rf_we), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mis", 32'(misalign_err), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      rst = 1'b0;

      run_txn(1, 0, 32'h1003, 32'h000000AB, 5'd0, 0, 0, 32'd0);
      run_txn(0, 0, 32'h2001, 32'd0, 5'd5, 0, 0, 32'h123480FF);
      run_txn(0, 4, 32'h2001, 32'd0, 5'd5, 0, 0, 32'h123480FF);
      run_txn(0, 1, 32'h2002, 32'd0, 5'd7, 0, 0, 32'h80010000);
      run_txn(0, 2, 32'h2000, 32'd0, 5'd0, 0, 0, 32'hDEADBEEF);
      run_txn(1, 2, 32'h3000, 32'hCAFEF00D, 5'd0, 3, 0, 32'd0);
      run_txn(0, 3, 32'h4000, 32'd0, 5'd9, 0, 0, 32'd0);
      run_txn(1, 4, 32'h4000, 32'h11, 5'd0, 0, 0, 32'd0);
      run_txn(0, 2, 32'h2001, 32'd0, 5'd3, 0, 0, 32'h89ABCDEF);
      run_txn(1, 1, 32'h5003, 32'h0000BEEF, 5'd0, 1, 0, 32'd0);

      // Reset while waiting for read data: the late rvalid must be ignored.
      begin
         bit ok;
         ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1; break; end
         end
         chk("rw_ready", 32'(ok), 32'd1);
         bus.req_valid  = 1'b1;
         bus.req_we     = 1'b0;
         bus.req_funct3 = 3'd2;
         bus.req_addr   = 32'h6000;
         bus.req_rd     = 5'd4;
         @(posedge clk);
         #1 bus.req_valid = 1'b0;
         bus.mem_ready = 1'b1;
         @(posedge clk);
         #1 bus.mem_ready = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         chk("rw_mvalid", 32'(bus.mem_valid), 32'd0);
         chk("rw_rfwe_rst", 32'(rf_we), 32'd0);
         rst = 1'b0;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'h55555555;
         @(posedge clk);
         #1 bus.mem_rvalid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rw_rfwe", 32'(rf_we), 32'd0);
            chk("rw_done", 32'(done), 32'd0);
            chk("rw_idle", 32'(bus.req_ready), 32'd1);
         end
      end

      for (int n = 0; n < 200; n++) begin
         run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 $urandom, $urandom, 5'($urandom_range(0, 31)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got %0d exp %0d", 0, 1);
      $fatal(1, "timeout");
   end
endmodule
